rob_commit: RTL and testbench

- Reorder buffer for the out-of-order core.
- Hands out the 3-bit tags the register file records on allocation.
- Captures results broadcast on the common data bus (CDB).
- Retires entries strictly in program order, one per cycle, by driving the register-file write port (load/dest/in).
- Provides two tag-indexed operand read ports, so dispatch can fetch values that are still in flight but already produced.

---
 rtl/rob_commit.sv | 149 ++++++++++++++
 tb/tb_rob_commit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// Reorder buffer: hands out tags, captures CDB results, retires in program order
// through the register-file write port, and serves two tag-indexed operand reads.
module rob_commit #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_req,
  input  logic [4:0]        alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              rf_load,
  output logic [4:0]        rf_dest,
  output logic [DATA_W-1:0] rf_data,
  output logic [TAG_W-1:0]  rf_tag,
  input  logic [TAG_W-1:0]  rd_tag_a,
  input  logic [TAG_W-1:0]  rd_tag_b,
  output logic              rd_ready_a,
  output logic              rd_ready_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [TAG_W:0]    count,
  output logic              empty
);

  localparam logic [TAG_W:0]   FULL_CNT = DEPTH[TAG_W:0];
  localparam logic [TAG_W:0]   CNT_ONE  = 1;
  localparam logic [TAG_W-1:0] TAG_ONE  = 1;

  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [TAG_W:0]    r_count;

  logic [DEPTH-1:0]  w_busy;
  logic [DEPTH-1:0]  w_done;
  logic [4:0]        w_dest [DEPTH];
  logic [DATA_W-1:0] w_data [DEPTH];

  logic w_alloc_fire;
  logic w_commit;
  logic w_cdb_hit;
  logic w_hit_a;
  logic w_hit_b;
  logic w_stored_a;
  logic w_stored_b;

  // alloc_ready looks at the registered count only, so a full ROB never
  // reuses the head slot in the cycle that slot retires.
  assign alloc_ready  = (r_count != FULL_CNT);
  assign alloc_tag    = r_tail;
  assign w_alloc_fire = alloc_req && alloc_ready;
  assign w_commit     = w_busy[r_head] && w_done[r_head];
  assign w_cdb_hit    = cdb_valid && w_busy[cdb_tag];

  assign count = r_count;
  assign empty = (r_count == '0);

  assign rf_load = w_commit;
  assign rf_dest = w_commit ? w_dest[r_head] : '0;
  assign rf_data = w_commit ? w_data[r_head] : '0;
  assign rf_tag  = w_commit ? r_head : '0;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [TAG_W-1:0] IDX = gi[TAG_W-1:0];

      logic              r_busy;
      logic              r_done;
      logic [4:0]        r_dest;
      logic [DATA_W-1:0] r_data;

      // Later assignments win: CDB capture, then retire, then allocate.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
          r_dest <= '0;
          r_data <= '0;
        end else if (flush) begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end else begin
          if (w_cdb_hit && (cdb_tag == IDX)) begin
            r_data <= cdb_data;
            r_done <= 1'b1;
          end
          if (w_commit && (r_head == IDX)) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
          end
          if (w_alloc_fire && (r_tail == IDX)) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_dest <= alloc_dest;
          end
        end
      end

      assign w_busy[gi] = r_busy;
      assign w_done[gi] = r_done;
      assign w_dest[gi] = r_dest;
      assign w_data[gi] = r_data;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc_fire) r_tail <= r_tail + TAG_ONE;
      if (w_commit)     r_head <= r_head + TAG_ONE;
      case ({w_alloc_fire, w_commit})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Operand reads: a same-cycle CDB broadcast to a busy entry is forwarded.
  always_comb begin
    w_hit_a    = cdb_valid && (cdb_tag == rd_tag_a) && w_busy[rd_tag_a];
    w_hit_b    = cdb_valid && (cdb_tag == rd_tag_b) && w_busy[rd_tag_b];
    w_stored_a = w_busy[rd_tag_a] && w_done[rd_tag_a];
    w_stored_b = w_busy[rd_tag_b] && w_done[rd_tag_b];
    rd_ready_a = w_hit_a || w_stored_a;
    rd_ready_b = w_hit_b || w_stored_b;
    rd_data_a  = '0;
    rd_data_b  = '0;
    if (w_hit_a)         rd_data_a = cdb_data;
    else if (w_stored_a) rd_data_a = w_data[rd_tag_a];
    if (w_hit_b)         rd_data_b = cdb_data;
    else if (w_stored_b) rd_data_b = w_data[rd_tag_b];
  end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus random traffic against a
// program-order queue model; commits are checked by a separate monitor.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        alloc_req = 1'b0;
  logic [4:0]  alloc_dest = '0;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic        rf_load;
  logic [4:0]  rf_dest;
  logic [31:0] rf_data;
  logic [2:0]  rf_tag;
  logic [2:0]  rd_tag_a = '0;
  logic [2:0]  rd_tag_b = '0;
  logic        rd_ready_a;
  logic        rd_ready_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [3:0]  count;
  logic        empty;

  rob_commit #(.DEPTH(8), .TAG_W(3), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_req(alloc_req), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rf_load(rf_load), .rf_dest(rf_dest), .rf_data(rf_data), .rf_tag(rf_tag),
    .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b),
    .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  tag;
    logic [4:0]  dest;
    bit          done;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [2:0]  tag;
    logic [4:0]  dest;
    logic [31:0] data;
  } cm_t;

  ent_t rob_q[$];      // in-flight instructions, oldest first
  int   m_head = 0;    // tag of the oldest instruction
  cm_t  exp_q[$];      // commits the model expects, consumed by the monitor

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    chk("rst_rf_load", 32'(rf_load), 32'd0);
    chk("rst_rf_dest", 32'(rf_dest), 32'd0);
    chk("rst_rf_data", rf_data, 32'd0);
    chk("rst_rf_tag", 32'(rf_tag), 32'd0);
    chk("rst_rd_ready_a", 32'(rd_ready_a), 32'd0);
    chk("rst_rd_ready_b", 32'(rd_ready_b), 32'd0);
    chk("rst_rd_data_a", rd_data_a, 32'd0);
    chk("rst_rd_data_b", rd_data_b, 32'd0);
  endtask

  // Model view of a read port for this cycle's inputs.
  task automatic model_read(input logic [2:0] t, output logic rdy, output logic [31:0] d);
    rdy = 1'b0;
    d   = '0;
    foreach (rob_q[i]) begin
      if (rob_q[i].tag == t) begin
        if (cdb_valid && cdb_tag == t) begin
          rdy = 1'b1;
          d   = cdb_data;
        end else if (rob_q[i].done) begin
          rdy = 1'b1;
          d   = rob_q[i].data;
        end
      end
    end
  endtask

  task automatic step(input logic a, input logic [4:0] d, input logic cv,
                      input logic [2:0] ct, input logic [31:0] cd, input logic fl,
                      input logic [2:0] ra, input logic [2:0] rb);
    int   sz;
    bit   do_commit;
    bit   do_alloc;
    int   new_tag;
    logic erdy;
    logic [31:0] edata;
    cm_t  c;
    ent_t e;
    @(posedge clk);
    #1;
    alloc_req = a;  alloc_dest = d;
    cdb_valid = cv; cdb_tag = ct; cdb_data = cd;
    flush = fl; rd_tag_a = ra; rd_tag_b = rb;
    sz = rob_q.size();
    do_commit = (sz > 0) && rob_q[0].done;
    if (do_commit) begin
      c.tag = rob_q[0].tag; c.dest = rob_q[0].dest; c.data = rob_q[0].data;
      exp_q.push_back(c);
    end
    #1;
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("alloc_ready", 32'(alloc_ready), 32'(sz < 8));
    chk("alloc_tag", 32'(alloc_tag), 32'((m_head + sz) % 8));
    model_read(ra, erdy, edata);
    chk("rd_ready_a", 32'(rd_ready_a), 32'(erdy));
    chk("rd_data_a", rd_data_a, edata);
    model_read(rb, erdy, edata);
    chk("rd_ready_b", 32'(rd_ready_b), 32'(erdy));
    chk("rd_data_b", rd_data_b, edata);
    // Advance the model to the state after the coming clock edge.
    if (fl) begin
      rob_q.delete();
      m_head = 0;
    end else begin
      do_alloc = a && (sz < 8);
      new_tag  = (m_head + sz) % 8;
      if (cv) begin
        foreach (rob_q[i]) begin
          if (rob_q[i].tag == ct) begin
            e = rob_q[i]; e.done = 1'b1; e.data = cd; rob_q[i] = e;
          end
        end
      end
      if (do_commit) begin
        void'(rob_q.pop_front());
        m_head = (m_head + 1) % 8;
      end
      if (do_alloc) begin
        e.tag = 3'(new_tag); e.dest = d; e.done = 1'b0; e.data = '0;
        rob_q.push_back(e);
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    alloc_req = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
    rd_tag_a = 3'($urandom_range(0, 7)); rd_tag_b = 3'($urandom_range(0, 7));
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    rob_q.delete();
    exp_q.delete();
    m_head = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Commit monitor: one expectation per model-predicted retire.
  initial begin
    cm_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rf_load === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_commit actual tag=%0d dest=%0d expected no commit", rf_tag, rf_dest);
          end else begin
            e = exp_q.pop_front();
            chk("commit_tag", 32'(rf_tag), 32'(e.tag));
            chk("commit_dest", 32'(rf_dest), 32'(e.dest));
            chk("commit_data", rf_data, e.data);
            $display("commit tag=%0d dest=%0d data=0x%0h", rf_tag, rf_dest, rf_data);
          end
        end else if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++; failures++;
          $display("FAIL missing_commit actual rf_load=0 expected tag=%0d dest=%0d", e.tag, e.dest);
        end else begin
          chk("idle_rf_data", rf_data, 32'd0);
          chk("idle_rf_dest", 32'(rf_dest), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [2:0] t;
    #1;
    chk_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Three allocations, then out-of-order results retire in order.
    step(1'b1, 5'd5, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd1);
    step(1'b1, 5'd6, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd1);
    step(1'b1, 5'd7, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd1);
    step(1'b0, 5'd0, 1'b1, 3'd1, 32'hBEEF, 1'b0, 3'd1, 3'd0);
    step(1'b0, 5'd0, 1'b1, 3'd0, 32'h1234, 1'b0, 3'd1, 3'd0);
    idle(); idle(); idle();

    // Fill to full, refused 9th request, retire one, wrap allocation.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 5'(i + 10), 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0);
    step(1'b1, 5'd31, 1'b0, 3'd0, 32'd0, 1'b0, 3'd7, 3'd0);
    step(1'b1, 5'd31, 1'b1, 3'd0, 32'h5A5A, 1'b0, 3'd0, 3'd7);
    step(1'b1, 5'd30, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0);
    step(1'b1, 5'd29, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0);
    idle();

    // Allocate and retire in the same cycle at count 4, then CDB bypass read.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 5'(i + 1), 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0);
    step(1'b0, 5'd0, 1'b1, 3'd0, 32'h77, 1'b0, 3'd0, 3'd0);
    step(1'b1, 5'd9, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0);
    step(1'b0, 5'd0, 1'b1, 3'd3, 32'hCAFE, 1'b0, 3'd3, 3'd2);
    step(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd3, 3'd2);
    idle();

    // Flush with five entries (two done) alongside an alloc and a CDB write.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 5'(i + 3), 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0);
    step(1'b0, 5'd0, 1'b1, 3'd1, 32'h11, 1'b0, 3'd1, 3'd2);
    step(1'b0, 5'd0, 1'b1, 3'd2, 32'h22, 1'b0, 3'd1, 3'd2);
    step(1'b1, 5'd8, 1'b1, 3'd3, 32'h33, 1'b1, 3'd1, 3'd3);
    idle(); idle(); idle();

    // Random traffic with an asynchronous reset partway through.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      if (rob_q.size() > 0 && $urandom_range(0, 3) != 0)
        t = rob_q[$urandom_range(0, rob_q.size() - 1)].tag;
      else
        t = 3'($urandom_range(0, 7));
      step(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), t, $urandom(),
           1'($urandom_range(0, 99) == 0),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    idle(); idle();
    @(posedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
